// File: rtl/egress_pop_ctrl.sv
// egress_pop_ctrl: round-robin pop controller draining four egress FIFOs into one registered output stream
module egress_pop_ctrl #(
  parameter int data_width = 10,
  parameter int num_fifos  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  pause,
  input  logic                  empty_P4,
  input  logic                  empty_P5,
  input  logic                  empty_P6,
  input  logic                  empty_P7,
  input  logic [data_width-1:0] data_P4,
  input  logic [data_width-1:0] data_P5,
  input  logic [data_width-1:0] data_P6,
  input  logic [data_width-1:0] data_P7,
  output logic                  pop_F0,
  output logic                  pop_F1,
  output logic                  pop_F2,
  output logic                  pop_F3,
  output logic                  IDLE,
  output logic [1:0]            state_out,
  output logic [data_width-1:0] data_out,
  output logic                  valid_out,
  output logic [1:0]            src_idx
);
  typedef enum logic [1:0] {S_RESET = 2'd0, S_INIT = 2'd1, S_IDLE = 2'd2, S_ACTIVE = 2'd3} state_t;
  state_t                r_state, w_next;
  logic [1:0]            r_rr, r_src, w_grant;
  logic [data_width-1:0] r_data, w_data;
  logic                  r_valid, w_pop;
  logic [num_fifos-1:0]  w_req, w_pops;
  always_comb begin
    w_req   = ~{empty_P7, empty_P6, empty_P5, empty_P4};
    w_grant = r_rr;
    // descending scan so the smallest offset from r_rr is the one that sticks
    for (int k = num_fifos - 1; k >= 0; k--)
      if (w_req[r_rr + 2'(k)]) w_grant = r_rr + 2'(k);
    // gating by reset keeps a word from leaving a FIFO when it could not be forwarded
    w_pop  = !reset && r_state == S_ACTIVE && !pause && |w_req;
    w_pops = w_pop ? {{(num_fifos-1){1'b0}}, 1'b1} << w_grant : '0;
    w_data = w_grant == 2'd0 ? data_P4 : w_grant == 2'd1 ? data_P5 : w_grant == 2'd2 ? data_P6 : data_P7;
  end
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET:  w_next = S_INIT;
      S_INIT:   w_next = init ? S_INIT : S_IDLE;
      S_IDLE:   w_next = init ? S_INIT : (|w_req && !pause) ? S_ACTIVE : S_IDLE;
      S_ACTIVE: w_next = init ? S_INIT : (!(|w_req) && !w_pop) ? S_IDLE : S_ACTIVE;
      default:  w_next = S_RESET;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RESET;
      r_rr    <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_src   <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_pop;
      if (w_pop) begin
        r_rr   <= w_grant + 2'd1;
        r_src  <= w_grant;
        r_data <= w_data;
      end
    end
  end
  assign {pop_F3, pop_F2, pop_F1, pop_F0} = w_pops;
  assign IDLE      = r_state == S_IDLE;
  assign state_out = r_state;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign src_idx   = r_src;
endmodule

// File: tb/tb_egress_pop_ctrl.sv
// tb_egress_pop_ctrl: randomized directed bench with queue-based FIFO and round-robin reference model
module tb_egress_pop_ctrl;
  logic       clk = 1'b0;
  logic       reset, init, pause;
  logic       empty_P4, empty_P5, empty_P6, empty_P7;
  logic [9:0] data_P4, data_P5, data_P6, data_P7;
  logic       pop_F0, pop_F1, pop_F2, pop_F3, IDLE, valid_out;
  logic [1:0] state_out, src_idx;
  logic [9:0] data_out;
  int vectors = 0, miscompares = 0;
  logic [9:0] q0[$], q1[$], q2[$], q3[$];
  int m_st = 0, m_rr = 0, m_src = 0;
  logic m_valid = 1'b0;
  logic [9:0] m_data = '0;
  int obs_cnt[4];
  always #5 clk = ~clk;
  egress_pop_ctrl dut (
    .clk(clk), .reset(reset), .init(init), .pause(pause),
    .empty_P4(empty_P4), .empty_P5(empty_P5), .empty_P6(empty_P6), .empty_P7(empty_P7),
    .data_P4(data_P4), .data_P5(data_P5), .data_P6(data_P6), .data_P7(data_P7),
    .pop_F0(pop_F0), .pop_F1(pop_F1), .pop_F2(pop_F2), .pop_F3(pop_F3),
    .IDLE(IDLE), .state_out(state_out), .data_out(data_out), .valid_out(valid_out), .src_idx(src_idx)
  );
  function automatic int qsize(int i);
    return i == 0 ? q0.size() : i == 1 ? q1.size() : i == 2 ? q2.size() : q3.size();
  endfunction
  function automatic void qpush(int i, logic [9:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction
  function automatic logic [9:0] qpop(int i);
    case (i)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction
  // next grant under the round-robin rule, -1 when nothing may be popped this cycle
  function automatic int pred_grant();
    if (reset || m_st != 3 || pause) return -1;
    for (int k = 0; k < 4; k++)
      if (qsize((m_rr + k) % 4) > 0) return (m_rr + k) % 4;
    return -1;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    int g, total, ns;
    empty_P4 = q0.size() == 0; data_P4 = q0.size() > 0 ? q0[0] : '0;
    empty_P5 = q1.size() == 0; data_P5 = q1.size() > 0 ? q1[0] : '0;
    empty_P6 = q2.size() == 0; data_P6 = q2.size() > 0 ? q2[0] : '0;
    empty_P7 = q3.size() == 0; data_P7 = q3.size() > 0 ? q3[0] : '0;
    #1;
    g = pred_grant();
    chk("pops", {28'd0, pop_F3, pop_F2, pop_F1, pop_F0}, g < 0 ? 32'd0 : 32'd1 << g);
    if (pop_F0) obs_cnt[0]++;
    if (pop_F1) obs_cnt[1]++;
    if (pop_F2) obs_cnt[2]++;
    if (pop_F3) obs_cnt[3]++;
    total = qsize(0) + qsize(1) + qsize(2) + qsize(3);
    @(posedge clk);
    if (reset) begin
      m_st = 0; m_rr = 0; m_src = 0; m_valid = 1'b0; m_data = '0;
    end else begin
      case (m_st)
        0: ns = 1;
        1: ns = init ? 1 : 2;
        2: ns = init ? 1 : (total > 0 && !pause) ? 3 : 2;
        default: ns = init ? 1 : (total == 0) ? 2 : 3;
      endcase
      m_valid = g >= 0;
      if (g >= 0) begin
        m_src = g; m_data = qpop(g); m_rr = (g + 1) % 4;
      end
      m_st = ns;
    end
    #1;
    chk("state_out", {30'd0, state_out}, m_st);
    chk("IDLE", {31'd0, IDLE}, {31'd0, m_st == 2});
    chk("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
    chk("src_idx", {30'd0, src_idx}, m_src);
    chk("data_out", {22'd0, data_out}, {22'd0, m_data});
  endtask
  task automatic do_init();
    reset = 1'b1; init = 1'b0; pause = 1'b0;
    repeat (2) cyc();
    reset = 1'b0; init = 1'b1;
    repeat (3) cyc();
    init = 1'b0;
    repeat (2) cyc();
    for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
  endtask
  initial begin
    int g;
    do_init();
    chk("init_idle_state", {30'd0, state_out}, 32'd2);
    qpush(2, 10'h011); qpush(2, 10'h022); qpush(2, 10'h033);
    repeat (6) cyc();
    chk("drain_cnt2", obs_cnt[2], 32'd3);
    chk("drain_back_idle", {31'd0, IDLE}, 32'd1);
    do_init();
    for (int i = 0; i < 4; i++) repeat (2) qpush(i, 10'($urandom));
    repeat (11) cyc();
    for (int i = 0; i < 4; i++) chk($sformatf("rr_cnt%0d", i), obs_cnt[i], 32'd2);
    do_init();
    repeat (2) begin qpush(0, 10'($urandom)); qpush(2, 10'($urandom)); end
    repeat (8) cyc();
    chk("skip_cnt0", obs_cnt[0], 32'd2);
    chk("skip_cnt1", obs_cnt[1], 32'd0);
    chk("skip_cnt2", obs_cnt[2], 32'd2);
    chk("skip_cnt3", obs_cnt[3], 32'd0);
    for (int i = 0; i < 4; i++) repeat (8) qpush(i, 10'($urandom));
    repeat (3) cyc();
    pause = 1'b1;
    repeat (4) cyc();
    pause = 1'b0;
    repeat (30) cyc();
    chk("pause_drained", qsize(0) + qsize(1) + qsize(2) + qsize(3), 32'd0);
    do_init();
    for (int i = 0; i < 4; i++) repeat (4) qpush(i, 10'($urandom));
    for (int n = 0; n < 20; n++) begin
      #1;
      g = pred_grant();
      if (g == 1) break;
      cyc();
    end
    reset = 1'b1;
    cyc();
    chk("midreset_state", {30'd0, state_out}, 32'd0);
    reset = 1'b0; init = 1'b1;
    cyc();
    init = 1'b0;
    repeat (25) cyc();
    repeat (400) begin
      if ($urandom_range(0, 2) == 0) qpush($urandom_range(0, 3), 10'($urandom));
      pause = $urandom_range(0, 4) == 0;
      init  = $urandom_range(0, 60) == 0;
      reset = $urandom_range(0, 150) == 0;
      cyc();
    end
    reset = 1'b0; init = 1'b0; pause = 1'b0;
    repeat (60) cyc();
    chk("soak_drained", qsize(0) + qsize(1) + qsize(2) + qsize(3), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
